// File: rtl/fetch_decode_stage.sv
// Fetch stage with IF/ID pipeline register: owns the PC, drives the instruction
// memory address and latches the fetched word with its PC, PC+4 and decoded fields.
module fetch_decode_stage #(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            stall_f_i,
   input  logic            stall_d_i,
   input  logic            flush_d_i,
   input  logic            pc_src_e_i,
   input  logic [XLEN-1:0] pc_target_e_i,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic [31:0]     imem_rdata_i,
   output logic [XLEN-1:0] pc_f_o,
   output logic [31:0]     instr_d_o,
   output logic [XLEN-1:0] pc_d_o,
   output logic [XLEN-1:0] pc_plus4_d_o,
   output logic            valid_d_o,
   output logic [6:0]      opcode_d_o,
   output logic [2:0]      funct3_d_o,
   output logic [6:0]      funct7_d_o,
   output logic [4:0]      rs1_d_o,
   output logic [4:0]      rs2_d_o,
   output logic [4:0]      rd_d_o,
   output logic            misalign_d_o
);

   localparam logic [XLEN-1:0] PcStep = XLEN'(4);

   logic [XLEN-1:0] pc_f_q, pc_f_d;
   logic [XLEN-1:0] pc_plus4_f;
   logic [31:0]     ifid_instr_q, ifid_instr_d;
   logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
   logic [XLEN-1:0] ifid_pc4_q, ifid_pc4_d;
   logic            ifid_valid_q, ifid_valid_d;
   logic            ifid_misalign_q, ifid_misalign_d;

   assign pc_plus4_f = pc_f_q + PcStep;

   // Redirect wins over stall so a taken branch is never lost behind a hazard.
   always_comb begin
      pc_f_d = pc_f_q;
      if (pc_src_e_i) begin
         pc_f_d = pc_target_e_i;
      end else if (!stall_f_i) begin
         pc_f_d = pc_plus4_f;
      end
   end

   always_comb begin
      ifid_instr_d    = ifid_instr_q;
      ifid_pc_d       = ifid_pc_q;
      ifid_pc4_d      = ifid_pc4_q;
      ifid_valid_d    = ifid_valid_q;
      ifid_misalign_d = ifid_misalign_q;
      if (flush_d_i) begin
         ifid_instr_d    = NOP_INSTR;
         ifid_pc_d       = '0;
         ifid_pc4_d      = '0;
         ifid_valid_d    = 1'b0;
         ifid_misalign_d = 1'b0;
      end else if (!stall_d_i) begin
         ifid_instr_d    = imem_rdata_i;
         ifid_pc_d       = pc_f_q;
         ifid_pc4_d      = pc_plus4_f;
         ifid_valid_d    = 1'b1;
         ifid_misalign_d = |pc_f_q[1:0];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_f_q          <= RESET_PC;
         ifid_instr_q    <= NOP_INSTR;
         ifid_pc_q       <= '0;
         ifid_pc4_q      <= '0;
         ifid_valid_q    <= 1'b0;
         ifid_misalign_q <= 1'b0;
      end else begin
         pc_f_q          <= pc_f_d;
         ifid_instr_q    <= ifid_instr_d;
         ifid_pc_q       <= ifid_pc_d;
         ifid_pc4_q      <= ifid_pc4_d;
         ifid_valid_q    <= ifid_valid_d;
         ifid_misalign_q <= ifid_misalign_d;
      end
   end

   assign imem_addr_o  = pc_f_q;
   assign pc_f_o       = pc_f_q;
   assign instr_d_o    = ifid_instr_q;
   assign pc_d_o       = ifid_pc_q;
   assign pc_plus4_d_o = ifid_pc4_q;
   assign valid_d_o    = ifid_valid_q;
   assign misalign_d_o = ifid_misalign_q;

   assign opcode_d_o = ifid_instr_q[6:0];
   assign funct3_d_o = ifid_instr_q[14:12];
   assign funct7_d_o = ifid_instr_q[31:25];
   assign rs1_d_o    = ifid_instr_q[19:15];
   assign rs2_d_o    = ifid_instr_q[24:20];
   assign rd_d_o     = ifid_instr_q[11:7];

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Bench for fetch_decode_stage: directed vector table, hand-written field/priority
// sequences and randomized control traffic against a behavioural pipeline model.
module tb_fetch_decode_stage;

   logic        clk_i = 1'b0;
   logic        rst_i, stall_f_i, stall_d_i, flush_d_i, pc_src_e_i;
   logic [31:0] pc_target_e_i, imem_addr_o, imem_rdata_i, pc_f_o, instr_d_o;
   logic [31:0] pc_d_o, pc_plus4_d_o;
   logic        valid_d_o, misalign_d_o;
   logic [6:0]  opcode_d_o, funct7_d_o;
   logic [2:0]  funct3_d_o;
   logic [4:0]  rs1_d_o, rs2_d_o, rd_d_o;

   int total = 0;
   int bad   = 0;

   // Behavioural model state: the PC and the contents of the IF/ID latch.
   logic [31:0] m_pc, m_instr, m_pcd, m_pc4;
   logic        m_valid, m_mis;

   fetch_decode_stage dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .stall_f_i     (stall_f_i),
      .stall_d_i     (stall_d_i),
      .flush_d_i     (flush_d_i),
      .pc_src_e_i    (pc_src_e_i),
      .pc_target_e_i (pc_target_e_i),
      .imem_addr_o   (imem_addr_o),
      .imem_rdata_i  (imem_rdata_i),
      .pc_f_o        (pc_f_o),
      .instr_d_o     (instr_d_o),
      .pc_d_o        (pc_d_o),
      .pc_plus4_d_o  (pc_plus4_d_o),
      .valid_d_o     (valid_d_o),
      .opcode_d_o    (opcode_d_o),
      .funct3_d_o    (funct3_d_o),
      .funct7_d_o    (funct7_d_o),
      .rs1_d_o       (rs1_d_o),
      .rs2_d_o       (rs2_d_o),
      .rd_d_o        (rd_d_o),
      .misalign_d_o  (misalign_d_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] imem(input logic [31:0] a);
      if (a == 32'h0000_0200) return 32'h40B5_0533;
      return {a[29:0], 2'b11} ^ 32'hA5C3_0000;
   endfunction

   assign imem_rdata_i = imem(imem_addr_o);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_model();
      chk("pc_f", pc_f_o, m_pc);
      chk("imem_addr", imem_addr_o, m_pc);
      chk("instr_d", instr_d_o, m_instr);
      chk("pc_d", pc_d_o, m_pcd);
      chk("pc_plus4_d", pc_plus4_d_o, m_pc4);
      chk("valid_d", 32'(valid_d_o), 32'(m_valid));
      chk("misalign_d", 32'(misalign_d_o), 32'(m_mis));
      chk("opcode_d", 32'(opcode_d_o), 32'(m_instr[6:0]));
      chk("funct3_d", 32'(funct3_d_o), 32'(m_instr[14:12]));
      chk("funct7_d", 32'(funct7_d_o), 32'(m_instr[31:25]));
      chk("rs1_d", 32'(rs1_d_o), 32'(m_instr[19:15]));
      chk("rs2_d", 32'(rs2_d_o), 32'(m_instr[24:20]));
      chk("rd_d", 32'(rd_d_o), 32'(m_instr[11:7]));
   endtask

   // Apply one cycle of controls, advance the model across the edge, then compare.
   task automatic step(input logic r, input logic sf, input logic sd, input logic fl,
                       input logic src, input logic [31:0] tgt);
      logic [31:0] fetched, old_pc;
      rst_i = r; stall_f_i = sf; stall_d_i = sd; flush_d_i = fl;
      pc_src_e_i = src; pc_target_e_i = tgt;
      @(posedge clk_i);
      if (r) begin
         m_pc = 32'h0; m_instr = 32'h13; m_pcd = 0; m_pc4 = 0; m_valid = 0; m_mis = 0;
      end else begin
         fetched = imem(m_pc);
         old_pc  = m_pc;
         if (src) m_pc = tgt;
         else if (!sf) m_pc = m_pc + 32'd4;
         if (fl) begin
            m_instr = 32'h13; m_pcd = 0; m_pc4 = 0; m_valid = 0; m_mis = 0;
         end else if (!sd) begin
            m_instr = fetched; m_pcd = old_pc; m_pc4 = old_pc + 32'd4;
            m_valid = 1'b1; m_mis = |old_pc[1:0];
         end
      end
      #1;
      chk_model();
   endtask

   typedef struct packed {
      logic        rst, sf, sd, fl, src;
      logic [31:0] tgt, e_pcf, e_pcd, e_pc4;
      logic        e_v, e_m;
   } vec_t;

   vec_t tbl[$];

   initial begin
      rst_i = 1'b1; stall_f_i = 0; stall_d_i = 0; flush_d_i = 0;
      pc_src_e_i = 0; pc_target_e_i = 0;
      m_pc = 0; m_instr = 32'h13; m_pcd = 0; m_pc4 = 0; m_valid = 0; m_mis = 0;

      //            rst sf sd fl src tgt            pc_f           pc_d           pc+4        v  m
      tbl.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0,     32'h0,     32'h0,     32'h0,     1'b0,1'b0});
      tbl.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0,     32'h0,     32'h0,     32'h0,     1'b0,1'b0});
      tbl.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,     32'h4,     32'h0,     32'h4,     1'b1,1'b0});
      tbl.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,     32'h8,     32'h4,     32'h8,     1'b1,1'b0});
      for (int i = 0; i < 3; i++)
         tbl.push_back('{1'b0,1'b1,1'b1,1'b0,1'b0, 32'h0,  32'h8,     32'h4,     32'h8,     1'b1,1'b0});
      tbl.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,     32'hC,     32'h8,     32'hC,     1'b1,1'b0});
      tbl.push_back('{1'b0,1'b0,1'b0,1'b1,1'b1, 32'h40,    32'h40,    32'h0,     32'h0,     1'b0,1'b0});
      tbl.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,     32'h44,    32'h40,    32'h44,    1'b1,1'b0});
      tbl.push_back('{1'b0,1'b1,1'b1,1'b1,1'b1, 32'h80,    32'h80,    32'h0,     32'h0,     1'b0,1'b0});
      tbl.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,     32'h84,    32'h80,    32'h84,    1'b1,1'b0});
      tbl.push_back('{1'b0,1'b0,1'b0,1'b1,1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0,1'b0});
      tbl.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,     32'h0,     32'hFFFF_FFFC, 32'h0, 1'b1,1'b0});
      tbl.push_back('{1'b0,1'b0,1'b0,1'b1,1'b1, 32'h102,   32'h102,   32'h0,     32'h0,     1'b0,1'b0});
      tbl.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,     32'h106,   32'h102,   32'h106,   1'b1,1'b1});
      // Fetch stalled, decode running: same word reloads each cycle.
      tbl.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0, 32'h0,     32'h106,   32'h106,   32'h10A,   1'b1,1'b1});
      tbl.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0, 32'h0,     32'h106,   32'h106,   32'h10A,   1'b1,1'b1});
      tbl.push_back('{1'b0,1'b0,1'b0,1'b1,1'b0, 32'h0,     32'h10A,   32'h0,     32'h0,     1'b0,1'b0});
      // Reset arriving during stall and redirect.
      tbl.push_back('{1'b1,1'b1,1'b1,1'b0,1'b1, 32'h300,   32'h0,     32'h0,     32'h0,     1'b0,1'b0});
      tbl.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,     32'h4,     32'h0,     32'h4,     1'b1,1'b0});

      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].sf, tbl[i].sd, tbl[i].fl, tbl[i].src, tbl[i].tgt);
         chk($sformatf("vec%0d pc_f", i), pc_f_o, tbl[i].e_pcf);
         chk($sformatf("vec%0d pc_d", i), pc_d_o, tbl[i].e_pcd);
         chk($sformatf("vec%0d pc_plus4_d", i), pc_plus4_d_o, tbl[i].e_pc4);
         chk($sformatf("vec%0d valid_d", i), 32'(valid_d_o), 32'(tbl[i].e_v));
         chk($sformatf("vec%0d misalign_d", i), 32'(misalign_d_o), 32'(tbl[i].e_m));
         chk($sformatf("vec%0d instr_d", i), instr_d_o,
             tbl[i].e_v ? imem(tbl[i].e_pcd) : 32'h0000_0013);
      end

      // Bubble decodes as addi x0,x0,0.
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200);
      chk("bubble opcode", 32'(opcode_d_o), 32'h13);
      chk("bubble rd", 32'(rd_d_o), 32'h0);
      // sub x10,x10,x11 field slicing.
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("sub instr", instr_d_o, 32'h40B5_0533);
      chk("sub opcode", 32'(opcode_d_o), 32'h33);
      chk("sub funct3", 32'(funct3_d_o), 32'h0);
      chk("sub funct7", 32'(funct7_d_o), 32'h20);
      chk("sub rs1", 32'(rs1_d_o), 32'd10);
      chk("sub rs2", 32'(rs2_d_o), 32'd11);
      chk("sub rd", 32'(rd_d_o), 32'd10);
      chk("sub pc_d", pc_d_o, 32'h200);

      for (int n = 0; n < 400; n++) begin
         logic [31:0] tgt;
         tgt = $urandom();
         if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
         step($urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 5) == 0, tgt);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
